// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destinations from EX through DEPTH
// later stages and produces per-source forward selects for EX plus a stall request for IF/ID.
module fwd_hazard_unit #(
    parameter int unsigned REG_W   = 4,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned FWD_EN  = 1,
    localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       freeze_i,
    input  logic                       flush_i,
    input  logic [NUM_SRC*REG_W-1:0]   id_src_i,
    input  logic [NUM_SRC-1:0]         id_src_vld_i,
    input  logic [REG_W-1:0]           id_dst_i,
    input  logic                       id_wb_en_i,
    input  logic                       id_is_load_i,
    output logic                       stall_o,
    output logic [NUM_SRC*SEL_W-1:0]   ex_sel_o,
    output logic [15:0]                stall_cnt_o
);

    logic                     ex_vld_q, ex_vld_d;
    logic [NUM_SRC*REG_W-1:0] ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]       ex_src_vld_q, ex_src_vld_d;
    logic [REG_W-1:0]         ex_dst_q, ex_dst_d;
    logic                     ex_wb_en_q, ex_wb_en_d;
    logic                     ex_is_load_q, ex_is_load_d;

    logic [DEPTH:1]             stg_vld_q, stg_vld_d;
    logic [DEPTH:1]             stg_wb_en_q, stg_wb_en_d;
    logic [DEPTH:1]             stg_is_load_q, stg_is_load_d;
    logic [DEPTH:1][REG_W-1:0]  stg_dst_q, stg_dst_d;

    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Unified view of stages 0..DEPTH, stage 0 being the EX slot.
    logic [DEPTH:0]            p_vld, p_wb, p_ld;
    logic [DEPTH:0][REG_W-1:0] p_dst;
    logic                      stall_raw;

    assign p_vld = {stg_vld_q, ex_vld_q};
    assign p_wb  = {stg_wb_en_q, ex_wb_en_q};
    assign p_ld  = {stg_is_load_q, ex_is_load_q};
    assign p_dst = {stg_dst_q, ex_dst_q};

    always_comb begin
        stall_raw = 1'b0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            if (id_src_vld_i[s]) begin
                if (FWD_EN != 0) begin
                    if (p_vld[0] && p_wb[0] && p_ld[0] &&
                        p_dst[0] == id_src_i[s*REG_W +: REG_W]) begin
                        stall_raw = 1'b1;
                    end
                end else begin
                    // Stage DEPTH is covered by the regfile's write-before-read.
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        if (p_vld[k] && p_wb[k] && p_dst[k] == id_src_i[s*REG_W +: REG_W]) begin
                            stall_raw = 1'b1;
                        end
                    end
                end
            end
        end
        stall_o = stall_raw & ~flush_i;
    end

    always_comb begin
        ex_sel_o = '0;
        if (FWD_EN != 0 && ex_vld_q) begin
            for (int s = 0; s < int'(NUM_SRC); s++) begin
                if (ex_src_vld_q[s]) begin
                    // Walk oldest to youngest so the youngest writer overrides.
                    for (int k = int'(DEPTH); k >= 1; k--) begin
                        if (p_vld[k] && p_wb[k] && p_dst[k] == ex_src_q[s*REG_W +: REG_W]) begin
                            ex_sel_o[s*SEL_W +: SEL_W] = SEL_W'(k);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        ex_vld_d      = ex_vld_q;
        ex_src_d      = ex_src_q;
        ex_src_vld_d  = ex_src_vld_q;
        ex_dst_d      = ex_dst_q;
        ex_wb_en_d    = ex_wb_en_q;
        ex_is_load_d  = ex_is_load_q;
        stg_vld_d     = stg_vld_q;
        stg_wb_en_d   = stg_wb_en_q;
        stg_is_load_d = stg_is_load_q;
        stg_dst_d     = stg_dst_q;
        stall_cnt_d   = stall_cnt_q;
        if (!freeze_i) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                stg_vld_d[k]     = p_vld[k-1];
                stg_wb_en_d[k]   = p_wb[k-1];
                stg_is_load_d[k] = p_ld[k-1];
                stg_dst_d[k]     = p_dst[k-1];
            end
            ex_vld_d     = ~(flush_i | stall_o);
            ex_src_d     = id_src_i;
            ex_src_vld_d = id_src_vld_i;
            ex_dst_d     = id_dst_i;
            ex_wb_en_d   = id_wb_en_i;
            ex_is_load_d = id_is_load_i;
            if (stall_o && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_vld_q      <= 1'b0;
            ex_src_q      <= '0;
            ex_src_vld_q  <= '0;
            ex_dst_q      <= '0;
            ex_wb_en_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            stg_vld_q     <= '0;
            stg_wb_en_q   <= '0;
            stg_is_load_q <= '0;
            stg_dst_q     <= '0;
            stall_cnt_q   <= '0;
        end else begin
            ex_vld_q      <= ex_vld_d;
            ex_src_q      <= ex_src_d;
            ex_src_vld_q  <= ex_src_vld_d;
            ex_dst_q      <= ex_dst_d;
            ex_wb_en_q    <= ex_wb_en_d;
            ex_is_load_q  <= ex_is_load_d;
            stg_vld_q     <= stg_vld_d;
            stg_wb_en_q   <= stg_wb_en_d;
            stg_is_load_q <= stg_is_load_d;
            stg_dst_q     <= stg_dst_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
